handshake_until_checker: RTL
============================

// Module: handshake_until_checker
// PURPOSE
//  Synthesizable multi-channel monitor for "$rose(valid) |-> valid until_with ready" (weak) and
//  "... s_until_with ready" (strong, bounded by TIMEOUT) on NUM_CH independent valid/ready pairs.
//  Sits beside handshake interfaces in RTL and regression benches; flags protocol violations in hardware.
// PARAMETERS
//  NUM_CH     4    number of monitored valid/ready channels
//  STRONG     '1   NUM_CH-bit mask; bit i=1 -> channel i uses s_until_with (timeout enforced)
//  TIMEOUT    16   max cycles in WAIT before a strong channel fails (>=1)
//  CNT_W      8    width of per-channel stats counters (saturating)
// PORTS
//  clk          in   1            clock, all sampling on posedge
//  rst_n        in   1            asynchronous active-low reset
//  valid        in   NUM_CH       per-channel valid
//  ready        in   NUM_CH       per-channel ready
//  pass         out  NUM_CH       1-cycle pulse: obligation satisfied
//  err_drop     out  NUM_CH       1-cycle pulse: valid fell before/without ready
//  err_tmo      out  NUM_CH       1-cycle pulse: strong channel timed out
//  pending      out  NUM_CH       level: obligation open (WAIT state)
//  err_sticky   out  1            set on any err_* pulse, cleared only by reset
//  first_err_ch out  $clog2(NUM_CH) channel of first error since reset (lowest index if simultaneous)
//  pass_cnt     out  NUM_CH*CNT_W per-channel pass count (stats option)
//  fail_cnt     out  NUM_CH*CNT_W per-channel fail count (stats option)
// BEHAVIOUR
//  - Reset: all outputs 0, valid_q=0, state=IDLE, wait counters 0. Valid high on the first
//    post-reset edge is therefore a rise.
//  - rise_i = valid[i] & ~valid_q[i]; valid_q updated every edge.
//  - Per-channel FSM IDLE/WAIT, evaluated on each posedge; pulses registered, visible next cycle:
//    IDLE: rise & ready -> pass, stay IDLE.  rise & ~ready -> WAIT, cnt=1.  else stay.
//    WAIT: valid & ready -> pass, IDLE.  ~valid (ready don't-care) -> err_drop, IDLE.
//          valid & ~ready & STRONG[i] & cnt==TIMEOUT -> err_tmo, IDLE.
//          else cnt=cnt+1 (weak channels: cnt saturates at TIMEOUT, no error).
//  - Priority in WAIT: pass > err_drop > err_tmo (ready on the TIMEOUT cycle is a pass).
//  - Return to IDLE with valid still high does not re-arm; a new rise is needed.
//  - Counter width $clog2(TIMEOUT+1); no wrap possible.
//  - pending[i] = (state_i==WAIT), registered.
//  - Channels fully independent; multiple pulses in one cycle legal.
//  - first_err_ch latches only while err_sticky==0.
//  - Async reset mid-WAIT: obligation discarded, no error reported.
// CONFIGURATION
//  HANDSHAKE_UNTIL_STATS_EN defined: pass_cnt/fail_cnt increment on pass / (err_drop|err_tmo),
//    saturating at 2**CNT_W-1, reset 0.
//  Not defined: pass_cnt/fail_cnt tied to 0, no counter flops.
// TESTING
//  1 ch0 weak: valid rises cyc5, ready cyc10, both drop cyc11 -> pass[0] once at cyc11, no errors.
//  2 ch1: valid rises cyc5, drops cyc8, ready never -> err_drop[1] at cyc9, err_sticky=1, first_err_ch=1.
//  3 ch2 strong, TIMEOUT=4: valid rises cyc3, held, ready never -> err_tmo[2] at cyc8; weak ch0 same stimulus -> pending stays 1.
//  4 ch3: valid & ready rise same edge -> pass[3] next cycle, pending[3] never set.
//  5 rst_n low at cyc7 mid-WAIT on ch0 -> all outputs 0 immediately; no error after release.
//  6 STATS_EN: 3 passes + 1 drop on ch0 -> pass_cnt[0]=3, fail_cnt[0]=1; force 300 passes with CNT_W=8 -> pass_cnt saturates at 255.

Source files
------------

// File: rtl/handshake_until_checker.sv
// Per-channel hardware monitor for "$rose(valid) |-> valid until_with ready" (weak) and s_until_with (strong).
// Optional saturating pass/fail statistics counters are built when HANDSHAKE_UNTIL_STATS_EN is defined.
module handshake_until_checker #(
    parameter int unsigned       NUM_CH  = 4,
    parameter logic [NUM_CH-1:0] STRONG  = '1,
    parameter int unsigned       TIMEOUT = 16,
    parameter int unsigned       CNT_W   = 8,
    localparam int unsigned      CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       valid,
    input  logic [NUM_CH-1:0]       ready,
    output logic [NUM_CH-1:0]       pass,
    output logic [NUM_CH-1:0]       err_drop,
    output logic [NUM_CH-1:0]       err_tmo,
    output logic [NUM_CH-1:0]       pending,
    output logic                    err_sticky,
    output logic [CH_W-1:0]         first_err_ch,
    output logic [NUM_CH*CNT_W-1:0] pass_cnt,
    output logic [NUM_CH*CNT_W-1:0] fail_cnt
);

    localparam int unsigned   TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic {StIdle, StWait} state_e;

    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [TW-1:0]     wcnt_q  [NUM_CH];
    logic [TW-1:0]     wcnt_d  [NUM_CH];
    logic [NUM_CH-1:0] valid_q;
    logic [NUM_CH-1:0] pass_ev, drop_ev, tmo_ev, err_ev;
    logic [CH_W-1:0]   first_ev;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pass_ev[i] = 1'b0;
            drop_ev[i] = 1'b0;
            tmo_ev[i]  = 1'b0;
            state_d[i] = state_q[i];
            wcnt_d[i]  = wcnt_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (valid[i] && !valid_q[i]) begin
                        if (ready[i]) begin
                            pass_ev[i] = 1'b1;
                        end else begin
                            state_d[i] = StWait;
                            wcnt_d[i]  = TW'(1);
                        end
                    end
                end
                StWait: begin
                    // Priority: pass, then drop, then timeout.
                    if (valid[i] && ready[i]) begin
                        pass_ev[i] = 1'b1;
                        state_d[i] = StIdle;
                        wcnt_d[i]  = '0;
                    end else if (!valid[i]) begin
                        drop_ev[i] = 1'b1;
                        state_d[i] = StIdle;
                        wcnt_d[i]  = '0;
                    end else if (STRONG[i] && (wcnt_q[i] == TMAX)) begin
                        tmo_ev[i]  = 1'b1;
                        state_d[i] = StIdle;
                        wcnt_d[i]  = '0;
                    end else if (wcnt_q[i] != TMAX) begin
                        wcnt_d[i] = wcnt_q[i] + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign err_ev = drop_ev | tmo_ev;

    // Descending scan so the lowest erroring channel wins.
    always_comb begin
        first_ev = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (err_ev[i]) first_ev = CH_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            pass         <= '0;
            err_drop     <= '0;
            err_tmo      <= '0;
            pending      <= '0;
            err_sticky   <= 1'b0;
            first_err_ch <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= StIdle;
                wcnt_q[i]  <= '0;
            end
        end else begin
            valid_q  <= valid;
            pass     <= pass_ev;
            err_drop <= drop_ev;
            err_tmo  <= tmo_ev;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                wcnt_q[i]  <= wcnt_d[i];
                pending[i] <= (state_d[i] == StWait);
            end
            if (!err_sticky && (|err_ev)) begin
                err_sticky   <= 1'b1;
                first_err_ch <= first_ev;
            end
        end
    end

`ifdef HANDSHAKE_UNTIL_STATS_EN
    logic [NUM_CH*CNT_W-1:0] pass_cnt_q, fail_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (pass_ev[i] && (pass_cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    pass_cnt_q[i*CNT_W +: CNT_W] <= pass_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
                if (err_ev[i] && (fail_cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    fail_cnt_q[i*CNT_W +: CNT_W] <= fail_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
`else
    assign pass_cnt = '0;
    assign fail_cnt = '0;
`endif

endmodule
